// File: rtl/inv_mix_columns_iter.sv
// Iterative AES InvMixColumns engine: one 32-bit column per clock, 4-cycle latency.
// Define INV_MIX_FWD_EN to add a fwd_mode input selecting the forward MixColumns matrix.
module inv_mix_columns_iter (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [127:0] in_state,
   input  logic         in_valid,
   output logic         in_ready,
`ifdef INV_MIX_FWD_EN
   input  logic         fwd_mode,
`endif
   output logic [127:0] out_state,
   output logic         out_valid,
   input  logic         out_ready
);

   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

   state_t       state;
   logic [1:0]   col;
   logic [127:0] work;
   logic [31:0]  col_in;
   logic [31:0]  col_out;
`ifdef INV_MIX_FWD_EN
   logic         fwd_q;
`endif

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
   endfunction

   function automatic logic [31:0] inv_col(input logic [31:0] c);
      logic [7:0] a  [4];
      logic [7:0] x2 [4];
      logic [7:0] x4 [4];
      logic [7:0] x8 [4];
      logic [7:0] m9 [4];
      logic [7:0] mb [4];
      logic [7:0] md [4];
      logic [7:0] me [4];
      logic [7:0] b  [4];
      for (int i = 0; i < 4; i++) begin
         a[i]  = c[8*i +: 8];
         x2[i] = xtime(a[i]);
         x4[i] = xtime(x2[i]);
         x8[i] = xtime(x4[i]);
         m9[i] = x8[i] ^ a[i];
         mb[i] = x8[i] ^ x2[i] ^ a[i];
         md[i] = x8[i] ^ x4[i] ^ a[i];
         me[i] = x8[i] ^ x4[i] ^ x2[i];
      end
      b[0] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
      b[1] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
      b[2] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
      b[3] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
      return {b[3], b[2], b[1], b[0]};
   endfunction

`ifdef INV_MIX_FWD_EN
   function automatic logic [31:0] fwd_col(input logic [31:0] c);
      logic [7:0] a  [4];
      logic [7:0] m2 [4];
      logic [7:0] m3 [4];
      logic [7:0] b  [4];
      for (int i = 0; i < 4; i++) begin
         a[i]  = c[8*i +: 8];
         m2[i] = xtime(a[i]);
         m3[i] = m2[i] ^ a[i];
      end
      b[0] = m2[0] ^ m3[1] ^ a[2]  ^ a[3];
      b[1] = a[0]  ^ m2[1] ^ m3[2] ^ a[3];
      b[2] = a[0]  ^ a[1]  ^ m2[2] ^ m3[3];
      b[3] = m3[0] ^ a[1]  ^ a[2]  ^ m2[3];
      return {b[3], b[2], b[1], b[0]};
   endfunction
`endif

   // Single-column datapath: select the current column, transform, write back.
   assign col_in = work[{col, 5'd0} +: 32];

`ifdef INV_MIX_FWD_EN
   assign col_out = fwd_q ? fwd_col(col_in) : inv_col(col_in);
`else
   assign col_out = inv_col(col_in);
`endif

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign out_state = work;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         col   <= 2'd0;
         work  <= '0;
`ifdef INV_MIX_FWD_EN
         fwd_q <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  work  <= in_state;
                  col   <= 2'd0;
                  state <= BUSY;
`ifdef INV_MIX_FWD_EN
                  fwd_q <= fwd_mode;
`endif
               end
            end
            BUSY: begin
               work[{col, 5'd0} +: 32] <= col_out;
               col <= col + 2'd1;
               if (col == 2'd3) state <= DONE;
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
